// File: rtl/wave_capture_if.sv
// Sample, control and readback bundle for wave_capture.
// Master drives samples/controls/read address; slave returns registered read data and status.
interface wave_capture_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  en;
  logic                  arm;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] trig_level;
  logic [ADDR_WIDTH-1:0] pre_trig;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  busy;
  logic                  done;

  modport master (
    output en, arm, din, trig_level, pre_trig, rd_addr,
    input  rd_data, busy, done
  );

  modport slave (
    input  en, arm, din, trig_level, pre_trig, rd_addr,
    output rd_data, busy, done
  );
endinterface

// File: rtl/wave_capture.sv
// Circular-RAM waveform recorder with pre-trigger history and rising-level trigger.
// Samples written on the en cycle; rd_data one cycle after rd_addr; no backpressure (en is a strobe).
module wave_capture #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  wave_capture_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_PRETRIG, S_ARMED, S_POST, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [DATA_WIDTH-1:0] r_ram [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_count;
  logic [ADDR_WIDTH-1:0] r_trig_addr;
  logic [ADDR_WIDTH-1:0] r_pre;
  logic [DATA_WIDTH-1:0] r_level;
  logic [DATA_WIDTH-1:0] r_prev;
  logic                  r_prev_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic                  w_arm_ok;
  logic                  w_cross;
  logic                  w_post_end;
  logic                  w_wr;
  logic [ADDR_WIDTH-1:0] w_count_inc;
  logic [ADDR_WIDTH-1:0] w_post_len;
  logic [ADDR_WIDTH-1:0] w_start_addr;

  assign w_arm_ok     = bus.arm && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_count_inc  = r_count + ADDR_WIDTH'(1);
  // depth - pre - 1 is simply the bitwise complement of pre
  assign w_post_len   = ~r_pre;
  assign w_post_end   = (r_state == S_POST) && (r_count == w_post_len);
  // The closing POST cycle with zero post samples must not overwrite the oldest pre sample
  assign w_wr         = bus.en && (r_state != S_DONE) && !w_post_end;
  assign w_cross      = bus.en && r_prev_valid && (r_prev < r_level) && (bus.din >= r_level);
  assign w_start_addr = r_trig_addr - r_pre;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.arm) begin
          w_next = (bus.pre_trig == '0) ? S_ARMED : S_PRETRIG;
        end
      end
      S_PRETRIG: begin
        if (bus.en && (w_count_inc == r_pre)) w_next = S_ARMED;
      end
      S_ARMED: begin
        if (w_cross) w_next = S_POST;
      end
      S_POST: begin
        if (w_post_end || (bus.en && (w_count_inc == w_post_len))) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (r_state)
      S_PRETRIG, S_ARMED, S_POST: bus.busy = 1'b1;
      S_DONE:                     bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_trig_addr  <= '0;
      r_pre        <= '0;
      r_level      <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr     <= r_wr_ptr + ADDR_WIDTH'(1);
        r_prev       <= bus.din;
        r_prev_valid <= 1'b1;
      end
      if (w_arm_ok) begin
        r_level      <= bus.trig_level;
        r_pre        <= bus.pre_trig;
        r_count      <= '0;
        r_prev_valid <= 1'b0;
      end else begin
        case (r_state)
          S_PRETRIG, S_POST: begin
            if (bus.en) r_count <= w_count_inc;
          end
          S_ARMED: begin
            if (w_cross) begin
              r_trig_addr <= r_wr_ptr;
              r_count     <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_ram[r_wr_ptr] <= bus.din;
  end

  // Readback is relative to the oldest kept pre-trigger sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_ram[w_start_addr + bus.rd_addr];
    end
  end

  assign bus.rd_data = r_rd_data;
endmodule

// File: doc/wave_capture.md
Name: wave_capture

Overview:
- Single-channel waveform recorder: the writer/capture counterpart to the ROM-based waveform generators.
- Continuously writes incoming samples into an internal circular RAM on each sample strobe.
- Arms on request and detects a rising crossing of a programmable level. Keeps a programmable number of pre-trigger samples, then freezes the buffer.
- Readback is trigger-relative, feeding the display/readout path (e.g. Vbuddy plot).

Parameters:
DATA_WIDTH, 8, sample width in bits
ADDR_WIDTH, 8, RAM address width; depth = 2**ADDR_WIDTH

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-low reset
en  input  1  sample strobe; din is valid and consumed on cycles where en=1
arm  input  1  single-cycle request to start a capture; honoured only in IDLE or DONE
din  input  DATA_WIDTH  incoming sample, unsigned
trig_level  input  DATA_WIDTH  trigger threshold, unsigned; sampled when arm is accepted
pre_trig  input  ADDR_WIDTH  number of samples to keep before the trigger sample; sampled when arm is accepted
rd_addr  input  ADDR_WIDTH  readback index relative to capture start (0 = oldest pre-trigger sample)
rd_data  output  DATA_WIDTH  registered readback data
busy  output  1  high in PRETRIG, ARMED, POST
done  output  1  high in DONE

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. On rst=0:
  - state=IDLE; wr_ptr, count, trig_addr, start_addr, prev_sample = 0; prev_valid=0.
  - rd_data=0, busy=0, done=0.
  - RAM contents are not reset.
- Write path: in IDLE, PRETRIG, ARMED and POST, every en=1 cycle writes din to RAM[wr_ptr] and increments wr_ptr, wrapping modulo 2**ADDR_WIDTH. No writes occur in DONE.
- History register: on every written sample, prev_sample<=din and prev_valid<=1. arm acceptance clears prev_valid.
- State machine:
  - IDLE:
    - arm=1 -> PRETRIG. Latch trig_level and pre_trig; count<=0.
    - If pre_trig==0, go straight to ARMED instead.
  - PRETRIG:
    - Each en increments count.
    - When count reaches pre_trig (i.e. on the pre_trig-th written sample since arm) -> ARMED.
  - ARMED: on an en cycle where prev_valid=1, prev_sample < level and din >= level (rising crossing):
    - Trigger fires. The current din is the trigger sample.
    - trig_addr<=wr_ptr (its address); start_addr<=wr_ptr - pre_trig (mod depth).
    - count<=0 -> POST.
    - A sample equal to level with prev also >= level does not trigger.
  - POST:
    - Each en increments count.
    - When count reaches depth - pre_trig - 1 -> DONE.
    - The final buffer holds pre_trig samples, the trigger sample, and the remainder after it, filling the RAM exactly once from start_addr.
  - DONE:
    - Buffer frozen.
    - arm=1 -> new capture exactly as from IDLE. Writing resumes from the current wr_ptr.
- arm while busy is ignored; latched level and pre_trig are unchanged.
- The trigger sample itself is written in the same cycle the trigger fires (write and transition coincide).
- Boundary cases:
  - pre_trig = depth-1: POST length 0; DONE is entered on the cycle after the trigger, with no post samples.
  - en=0 in any state: no state/count change (except arm in IDLE/DONE).
  - arm and en in the same cycle in IDLE: that sample is written; count starts at 0 (sample not counted toward pre-trigger); prev_valid cleared.
- Readback:
  - Physical address = start_addr + rd_addr (mod depth).
  - rd_data is registered: it reflects RAM at that address one cycle after rd_addr is applied.
  - Readback is valid in DONE. In other states it returns whatever the RAM holds.
- Reset mid-capture returns to IDLE immediately; busy/done drop asynchronously.

Test Plan:
- Reset values: hold rst=0 with en toggling -> rd_data=0, busy=0, done=0. Release rst -> IDLE.
- Basic capture: pre_trig=16, trig_level=128, arm at wr_ptr=0, then en=1 every cycle with din ramp 0,1,2,...,255,0,...
  - ARMED after din=15.
  - Trigger on din=128 (prev 127); trig_addr=128, start_addr=112.
  - done rises after 239 further samples.
  - rd_addr=0 -> rd_data=112 next cycle; rd_addr=16 -> 128; rd_addr=255 -> 111.
- No false trigger: level=100, din held at 150 after arm -> stays ARMED indefinitely.
  - Then din=50 followed by 100 -> trigger on the 100.
- pre_trig=0 and pre_trig=255: ramp input, level=10.
  - pre_trig=0: rd_addr=0 reads 10.
  - pre_trig=255: done one cycle after trigger; rd_addr=255 reads 10.
- Busy/arm interactions: arm pulse during POST -> ignored, capture completes unchanged.
  - arm in DONE -> busy reasserts; new capture overwrites.
  - en gaps (en=1 every 3rd cycle) give identical buffer contents.
- Reset mid-capture: assert rst during POST -> busy=0, done=0, wr_ptr=0 immediately.
  - A subsequent arm works normally.
